// File: rtl/memory_stage.sv
// MEM stage: passes ALU results through in one cycle, runs loads/stores on a req/gnt/rvalid
// bus, and presents a registered result bank to WriteBack. States: IDLE idle/accept | REQ bus request | WAIT response.
module memory_stage #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CONTROL_BIT  = 5,
  parameter int MEMREAD      = 0,
  parameter int MEMWRITE     = 1,
  parameter int REGEN        = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [31:0]            ex_instr_i,
  input  logic [CONTROL_BIT-1:0] ex_control_i,
  input  logic [31:0]            ex_aluResult_i,
  input  logic [31:0]            ex_storeData_i,
  input  logic [4:0]             ex_rd_addr_i,
  input  logic [31:0]            ex_pcplus_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [31:0]            dmem_addr_o,
  output logic [3:0]             dmem_be_o,
  output logic [31:0]            dmem_wdata_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [31:0]            dmem_rdata_i,
  output logic [31:0]            mem_instr_o,
  output logic [CONTROL_BIT-1:0] mem_control_o,
  output logic [31:0]            mem_aluResult_o,
  output logic [31:0]            mem_readData_o,
  output logic [31:0]            mem_pcplus_o,
  output logic [31:0]            mem_rd_addr_o,
  input  logic                   wb_ready_i,
  output logic                   misalign_o,
  output logic                   bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_TIMEOUT);
  localparam logic [CONTROL_BIT-1:0] REGEN_M = CONTROL_BIT'(1) << REGEN;
  localparam logic [CONTROL_BIT-1:0] MEMWRITE_M = CONTROL_BIT'(1) << MEMWRITE;

  state_t state_q, state_d;

  logic                   bank_full_q;
  logic [31:0]            op_instr_q, op_alu_q, op_pcplus_q;
  logic [CONTROL_BIT-1:0] op_control_q;
  logic [4:0]             op_rd_q;
  logic [CW-1:0]          cnt_q;
  logic                   err_q, resp_q;
  logic [31:0]            resp_data_q;

  logic                   bank_free, accept, ex_is_mem, ex_mis, tmo_hit;
  logic [1:0]             ex_off;
  logic [3:0]             ex_be;
  logic                   ld_ex, ld_op, ld_err, latch_op, set_mis, set_resp, set_err;
  logic [31:0]            rsrc, lane, load_ext;

  assign bank_free  = !bank_full_q || wb_ready_i;
  assign ex_ready_o = (state_q == S_IDLE) && bank_free;
  assign accept     = ex_valid_i && ex_ready_o;
  assign dmem_req_o = (state_q == S_REQ);

  assign ex_off    = ex_aluResult_i[1:0];
  assign ex_is_mem = ex_control_i[MEMREAD] || ex_control_i[MEMWRITE];
  assign ex_mis    = (ex_instr_i[13:12] == 2'b01 && ex_off[0]) ||
                     (ex_instr_i[13] && ex_off != 2'b00);

  always_comb begin
    ex_be = 4'b1111;
    case (ex_instr_i[13:12])
      2'b00:   ex_be = 4'b0001 << ex_off;
      2'b01:   ex_be = 4'b0011 << ex_off;
      default: ex_be = 4'b1111;
    endcase
  end

  assign tmo_hit = (WAIT_TIMEOUT != 0) && (cnt_q == CW'(1)) && !err_q && !resp_q;

  // A response that arrives while the bank is still held is parked in resp_data_q.
  assign rsrc = resp_q ? resp_data_q : dmem_rdata_i;
  assign lane = rsrc >> {op_alu_q[1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (op_instr_q[14:12])
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ld_ex    = 1'b0;
    ld_op    = 1'b0;
    ld_err   = 1'b0;
    latch_op = 1'b0;
    set_mis  = 1'b0;
    set_resp = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ex_is_mem && !ex_mis) begin
            latch_op = 1'b1;
            state_d  = S_REQ;
          end else begin
            ld_ex   = 1'b1;
            set_mis = ex_is_mem;
          end
        end
      end
      S_REQ: begin
        if (tmo_hit) begin
          if (bank_free) begin
            ld_op   = 1'b1;
            ld_err  = 1'b1;
            state_d = S_IDLE;
          end else begin
            set_err = 1'b1;
            state_d = S_WAIT;
          end
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (err_q || resp_q || dmem_rvalid_i) begin
          if (bank_free) begin
            ld_op   = 1'b1;
            ld_err  = err_q;
            state_d = S_IDLE;
          end else if (!err_q && !resp_q) begin
            set_resp = 1'b1;
          end
        end else if (tmo_hit) begin
          if (bank_free) begin
            ld_op   = 1'b1;
            ld_err  = 1'b1;
            state_d = S_IDLE;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_instr_q   <= '0;
      op_control_q <= '0;
      op_alu_q     <= '0;
      op_pcplus_q  <= '0;
      op_rd_q      <= '0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_q       <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if (latch_op) begin
        op_instr_q   <= ex_instr_i;
        op_control_q <= ex_control_i;
        op_alu_q     <= ex_aluResult_i;
        op_pcplus_q  <= ex_pcplus_i;
        op_rd_q      <= ex_rd_addr_i;
        dmem_we_o    <= ex_control_i[MEMWRITE];
        dmem_addr_o  <= {ex_aluResult_i[31:2], 2'b00};
        dmem_be_o    <= ex_be;
        dmem_wdata_o <= ex_storeData_i << {ex_off, 3'b000};
        cnt_q        <= CNT_LOAD;
      end else if (state_q != S_IDLE && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (ld_op) begin
        err_q  <= 1'b0;
        resp_q <= 1'b0;
      end else begin
        if (set_err) err_q <= 1'b1;
        if (set_resp) begin
          resp_q      <= 1'b1;
          resp_data_q <= dmem_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_full_q     <= 1'b0;
      mem_instr_o     <= '0;
      mem_control_o   <= '0;
      mem_aluResult_o <= '0;
      mem_readData_o  <= '0;
      mem_pcplus_o    <= '0;
      mem_rd_addr_o   <= '0;
      misalign_o      <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      misalign_o <= set_mis;
      bus_err_o  <= ld_op && ld_err;
      if (ld_ex) begin
        bank_full_q     <= 1'b1;
        mem_instr_o     <= ex_instr_i;
        mem_control_o   <= set_mis ? (ex_control_i & ~(REGEN_M | MEMWRITE_M)) : ex_control_i;
        mem_aluResult_o <= ex_aluResult_i;
        mem_readData_o  <= '0;
        mem_pcplus_o    <= ex_pcplus_i;
        mem_rd_addr_o   <= {27'b0, ex_rd_addr_i};
      end else if (ld_op) begin
        bank_full_q     <= 1'b1;
        mem_instr_o     <= op_instr_q;
        mem_control_o   <= ld_err ? (op_control_q & ~REGEN_M) : op_control_q;
        mem_aluResult_o <= op_alu_q;
        mem_readData_o  <= (!ld_err && op_control_q[MEMREAD]) ? load_ext : 32'b0;
        mem_pcplus_o    <= op_pcplus_q;
        mem_rd_addr_o   <= {27'b0, op_rd_q};
      end else if (wb_ready_i) begin
        // Consumed with nothing new: present a bubble.
        bank_full_q     <= 1'b0;
        mem_instr_o     <= '0;
        mem_control_o   <= '0;
        mem_aluResult_o <= '0;
        mem_readData_o  <= '0;
        mem_pcplus_o    <= '0;
        mem_rd_addr_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: one DUT with the default timeout, a second with
// WAIT_TIMEOUT=4 and a silent bus for the timeout case.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid, t_valid;
  logic [31:0] ex_instr, ex_alu, ex_store, ex_pcplus;
  logic [4:0]  ex_control;
  logic [4:0]  ex_rd;
  logic        gnt, rvalid, wb_ready;
  logic [31:0] rdata;

  logic        ex_ready, req, we, misalign, bus_err;
  logic [31:0] addr, wdata, m_instr, m_alu, m_rdata, m_pcplus, m_rd;
  logic [3:0]  be;
  logic [4:0]  m_control;

  logic        t_ex_ready, t_req, t_we, t_misalign, t_bus_err;
  logic [31:0] t_addr, t_wdata, t_instr, t_alu, t_rdata, t_pcplus, t_rd;
  logic [3:0]  t_be;
  logic [4:0]  t_control;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [4:0] C_ALU   = 5'b00100;
  localparam logic [4:0] C_LOAD  = 5'b01101;
  localparam logic [4:0] C_STORE = 5'b00010;

  always #5 clk_i = ~clk_i;

  memory_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_instr_i(ex_instr),
    .ex_control_i(ex_control), .ex_aluResult_i(ex_alu), .ex_storeData_i(ex_store),
    .ex_rd_addr_i(ex_rd), .ex_pcplus_i(ex_pcplus),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .mem_instr_o(m_instr), .mem_control_o(m_control), .mem_aluResult_o(m_alu),
    .mem_readData_o(m_rdata), .mem_pcplus_o(m_pcplus), .mem_rd_addr_o(m_rd),
    .wb_ready_i(wb_ready), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  memory_stage #(.WAIT_TIMEOUT(4)) dut_to (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(t_valid), .ex_ready_o(t_ex_ready), .ex_instr_i(ex_instr),
    .ex_control_i(ex_control), .ex_aluResult_i(ex_alu), .ex_storeData_i(ex_store),
    .ex_rd_addr_i(ex_rd), .ex_pcplus_i(ex_pcplus),
    .dmem_req_o(t_req), .dmem_we_o(t_we), .dmem_addr_o(t_addr), .dmem_be_o(t_be),
    .dmem_wdata_o(t_wdata), .dmem_gnt_i(1'b0), .dmem_rvalid_i(1'b0), .dmem_rdata_i(rdata),
    .mem_instr_o(t_instr), .mem_control_o(t_control), .mem_aluResult_o(t_alu),
    .mem_readData_o(t_rdata), .mem_pcplus_o(t_pcplus), .mem_rd_addr_o(t_rd),
    .wb_ready_i(1'b1), .misalign_o(t_misalign), .bus_err_o(t_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; ex_valid = 1'b0; t_valid = 1'b0;
    ex_instr = '0; ex_alu = '0; ex_store = '0; ex_pcplus = '0;
    ex_control = '0; ex_rd = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; wb_ready = 1'b1;
    tick(); tick();
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_be", {28'b0, be}, 32'd0);
    check("rst_control", {27'b0, m_control}, 32'd0);
    check("rst_rd", m_rd, 32'd0);
    check("rst_pulses", {30'b0, misalign, bus_err}, 32'd0);
    check("rst_ready", {31'b0, ex_ready}, 32'd1);
    rst_ni = 1'b1;
    tick();

    // ALU pass-through
    ex_valid = 1'b1; ex_instr = 32'h00000033; ex_control = C_ALU;
    ex_alu = 32'h1234; ex_rd = 5'd5; ex_pcplus = 32'h104;
    #1 check("alu_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    check("alu_control", {27'b0, m_control}, {27'b0, C_ALU});
    check("alu_result", m_alu, 32'h1234);
    check("alu_rd", m_rd, 32'd5);
    check("alu_rdata", m_rdata, 32'd0);
    check("alu_pcplus", m_pcplus, 32'h104);
    tick();
    check("alu_bubble", {27'b0, m_control}, 32'd0);

    // LB at 0x1003, grant with request, data next cycle
    ex_valid = 1'b1; ex_instr = 32'h00000003; ex_control = C_LOAD;
    ex_alu = 32'h1003; ex_rd = 5'd7; gnt = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("lb_req", {31'b0, req}, 32'd1);
    check("lb_addr", addr, 32'h1000);
    check("lb_be", {28'b0, be}, 32'h8);
    check("lb_we", {31'b0, we}, 32'd0);
    check("lb_ready_req", {31'b0, ex_ready}, 32'd0);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80FFFFFF;
    check("lb_req_wait", {31'b0, req}, 32'd0);
    check("lb_ready_wait", {31'b0, ex_ready}, 32'd0);
    tick();
    rvalid = 1'b0;
    check("lb_rdata", m_rdata, 32'hFFFFFF80);
    check("lb_rd", m_rd, 32'd7);
    check("lb_control", {27'b0, m_control}, {27'b0, C_LOAD});
    check("lb_ready_done", {31'b0, ex_ready}, 32'd1);

    // SH at 0x2002, grant in the fourth request cycle
    ex_valid = 1'b1; ex_instr = 32'h00001023; ex_control = C_STORE;
    ex_alu = 32'h2002; ex_store = 32'h0000ABCD; ex_rd = 5'd0;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sh_req", {31'b0, req}, 32'd1);
      check("sh_addr", addr, 32'h2000);
      check("sh_be", {28'b0, be}, 32'hC);
      check("sh_wdata", wdata, 32'hABCD0000);
      check("sh_we", {31'b0, we}, 32'd1);
      if (i == 3) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;
    check("sh_req_wait", {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    rvalid = 1'b0;
    check("sh_control", {27'b0, m_control}, {27'b0, C_STORE});
    check("sh_regen", {31'b0, m_control[2]}, 32'd0);
    check("sh_rdata", m_rdata, 32'd0);

    // Misaligned LW at 0x3001
    ex_valid = 1'b1; ex_instr = 32'h00002003; ex_control = C_LOAD;
    ex_alu = 32'h3001; ex_rd = 5'd3;
    #1 check("mis_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    check("mis_req", {31'b0, req}, 32'd0);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_control", {27'b0, m_control}, 32'h09);
    check("mis_rdata", m_rdata, 32'd0);
    tick();
    check("mis_pulse_end", {31'b0, misalign}, 32'd0);
    check("mis_req_after", {31'b0, req}, 32'd0);

    // Timeout on the WAIT_TIMEOUT=4 instance
    t_valid = 1'b1; ex_instr = 32'h00002003; ex_control = C_LOAD;
    ex_alu = 32'h4000; ex_rd = 5'd4;
    tick();
    t_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", {31'b0, t_req}, 32'd1);
      check("tmo_err_early", {31'b0, t_bus_err}, 32'd0);
      tick();
    end
    check("tmo_req_drop", {31'b0, t_req}, 32'd0);
    check("tmo_err", {31'b0, t_bus_err}, 32'd1);
    check("tmo_control", {27'b0, t_control}, 32'h09);
    tick();
    check("tmo_err_end", {31'b0, t_bus_err}, 32'd0);

    // Back-pressure: bank held while WriteBack stalls
    wb_ready = 1'b0;
    ex_valid = 1'b1; ex_instr = 32'h00000033; ex_control = C_ALU;
    ex_alu = 32'hAAAA; ex_rd = 5'd9;
    tick();
    ex_alu = 32'hBBBB; ex_rd = 5'd10;
    #1 check("bp_ready", {31'b0, ex_ready}, 32'd0);
    tick();
    check("bp_hold_alu", m_alu, 32'hAAAA);
    check("bp_hold_rd", m_rd, 32'd9);
    tick();
    check("bp_hold_alu2", m_alu, 32'hAAAA);
    wb_ready = 1'b1;
    #1 check("bp_ready_free", {31'b0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    check("bp_next_alu", m_alu, 32'hBBBB);
    check("bp_next_rd", m_rd, 32'd10);

    // Reset during REQ, then a stale response
    ex_valid = 1'b1; ex_instr = 32'h00002003; ex_control = C_LOAD;
    ex_alu = 32'h5000; ex_rd = 5'd11;
    tick();
    ex_valid = 1'b0;
    check("rr_req", {31'b0, req}, 32'd1);
    #2 rst_ni = 1'b0;
    #1 check("rr_req_drop", {31'b0, req}, 32'd0);
    tick();
    rst_ni = 1'b1;
    rvalid = 1'b1; rdata = 32'h12345678;
    tick();
    rvalid = 1'b0;
    check("rr_control", {27'b0, m_control}, 32'd0);
    check("rr_rdata", m_rdata, 32'd0);
    check("rr_ready", {31'b0, ex_ready}, 32'd1);
    check("rr_req_idle", {31'b0, req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
